alu_unit: RTL and testbench



---
 rtl/alu_unit.sv | 72 +++++++
 tb/tb_alu_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// Registered integer ALU: ten RISC-style operations selected by {funct7[5], funct3}.
// Result and valid are registered for one cycle of latency. The zero flag is decoded from the registered result.
module alu_unit #(
  parameter  int WIDTH = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             out_valid
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  logic [WIDTH-1:0] result_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_out_r;
  logic             out_valid_r;

  assign shamt_s = B[SHW-1:0];

  // Combinational operation decode; unassigned opcodes produce zero
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (alu_op)
      OP_ADD:  result_s = A + B;
      OP_SUB:  result_s = A - B;
      OP_SLL:  result_s = A << shamt_s;
      OP_SRL:  result_s = A >> shamt_s;
      OP_SRA:  result_s = $signed(A) >>> shamt_s;
      OP_SLT:  result_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: result_s = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_XOR:  result_s = A ^ B;
      OP_OR:   result_s = A | B;
      OP_AND:  result_s = A & B;
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // Result register: captures only on valid input, so idle cycles hold the last result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out_r   <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      alu_out_r   <= result_s;
      out_valid_r <= 1'b1;
    end else begin
      alu_out_r   <= alu_out_r;
      out_valid_r <= 1'b0;
    end
  end

  assign alu_out   = alu_out_r;
  assign out_valid = out_valid_r;
  assign zero      = (alu_out_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: stimulus pushes reference results and a negedge monitor pops and compares them.
module tb_alu_unit;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_op = 4'b0000;
  logic [W-1:0] alu_out;
  logic         zero;
  logic         out_valid;

  alu_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
    .alu_op(alu_op), .alu_out(alu_out), .zero(zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hold_val = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Reference model from the arithmetic definition of each opcode
  function automatic int model(input int op, input int ua, input int ub);
    int sa, sb_v, sh, p, r;
    sa   = (ua >= M/2) ? ua - M : ua;
    sb_v = (ub >= M/2) ? ub - M : ub;
    sh   = ub % W;
    p    = 1 << sh;
    case (op)
      0:  r = (ua + ub) % M;
      8:  r = (ua - ub + M) % M;
      1:  r = (ua * p) % M;
      5:  r = ua / p;
      13: begin
        r = (sa - (((sa % p) + p) % p)) / p;
        r = (r + M) % M;
      end
      2:  r = (sa < sb_v) ? 1 : 0;
      3:  r = (ua < ub) ? 1 : 0;
      4:  r = ua ^ ub;
      6:  r = ua | ub;
      7:  r = ua & ub;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic issue(input int op, input int va, input int vb);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = op[3:0];
    a        = va[W-1:0];
    b        = vb[W-1:0];
    e.exp = model(op, va, vb);
    e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    alu_op   = 4'($urandom);
  endtask

  task automatic do_reset(input int edges);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    alu_op   = 4'b0000;
    a        = W'(5);
    b        = W'(6);
    @(posedge clk);
    #1;
    sb.delete();
    hold_val = 0;
    repeat (edges - 1) @(posedge clk);
    @(negedge clk);
    chk("reset_out", int'(alu_out), 0);
    chk("reset_zero", int'(zero), 1);
    chk("reset_valid", int'(out_valid), 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per valid output, otherwise checks the held value
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.due);
          chk("result", int'(alu_out), e.exp);
          chk("zero", int'(zero), (e.exp == 0) ? 1 : 0);
          hold_val = e.exp;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("missing_valid", 0, 1);
        end
        chk("hold", int'(alu_out), hold_val);
        chk("hold_zero", int'(zero), (hold_val == 0) ? 1 : 0);
      end
    end
  end

  initial begin
    int r;
    do_reset(2);
    mon_en = 1'b1;
    idle();
    // Directed cases: arithmetic, shifts, compares, logic, undefined opcode
    issue(0, 4'b0101, 4'b1010);  issue(0, 4'b1101, 4'b1010);
    issue(8, 4'b0101, 4'b1010);  issue(8, 4'b0100, 4'b0100);
    issue(8, 4'b1000, 4'b0001);  issue(2, 4'b1000, 4'b0111);
    issue(1, 4'b0111, 4'b0001);  issue(5, 4'b1100, 4'b0010);
    issue(5, 4'b1010, 4'b0001);  issue(13, 4'b1010, 4'b0001);
    issue(13, 4'b0010, 4'b0001); issue(1, 4'b0011, 4'b0101);
    issue(1, 4'b1011, 4'b0000);  issue(13, 4'b1001, 4'b1111);
    issue(2, 4'b1010, 4'b0001);  issue(2, 4'b1010, 4'b1001);
    issue(2, 4'b1010, 4'b1101);  issue(2, 4'b0110, 4'b0110);
    issue(3, 4'b1001, 4'b0110);  issue(3, 4'b1001, 4'b1110);
    issue(3, 4'b1001, 4'b1001);  issue(7, 4'b1011, 4'b1101);
    issue(6, 4'b1101, 4'b1011);  issue(4, 4'b1011, 4'b1101);
    issue(4, 4'b1001, 4'b1001);  issue(15, 4'b1111, 4'b1111);
    for (int op = 9; op <= 14; op++) begin
      if (op != 13) issue(op, 4'b1111, 4'b0111);
    end
    // Back-to-back then idle: SUB result must be held
    issue(0, 4'b0011, 4'b0100);
    issue(8, 4'b0011, 4'b0001);
    repeat (3) idle();
    // Mid-stream reset discards in-flight work
    issue(0, 4'b0110, 4'b0001);
    issue(6, 4'b0101, 4'b0010);
    do_reset(1);
    issue(7, 4'b1111, 4'b0110);
    idle();
    // Randomized traffic with idles and occasional resets
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20) idle();
      else if (r < 22) do_reset(1);
      else issue(int'($urandom_range(0, 15)), int'($urandom_range(0, M-1)), int'($urandom_range(0, M-1)));
    end
    repeat (3) idle();
    chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
